// File: rtl/fpu_seq.sv
// fpu_seq: two-requester sequencer in front of a single-issue FPU.
// Arbitrates round-robin between two requesters and captures the winning op.
// Pulses the FPU reset for one cycle, then runs the FPU until it reports done
// or the cycle budget runs out, and returns the result on a valid/ready port.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready [1:0]   per-requester handshake (ready is one-hot)
//   req_op/req_a/req_b/req_rm   packed {req1,req0} op, operands, rounding mode
//   fpu_opcode/in1/in2/round    operation presented to the FPU
//   fpu_rst, fpu_act            FPU reset / activate
//   fpu_out, fpu_flags, fpu_done FPU result, flags, completion
//   rsp_valid/rsp_ready         response handshake
//   rsp_id, rsp_data, rsp_flags, rsp_timeout  response payload
module fpu_seq #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [5:0]  req_op,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   input  logic [5:0]  req_rm,
   output logic [2:0]  fpu_opcode,
   output logic [31:0] fpu_in1,
   output logic [31:0] fpu_in2,
   output logic [2:0]  fpu_round,
   output logic        fpu_rst,
   output logic        fpu_act,
   input  logic [31:0] fpu_out,
   input  logic [7:0]  fpu_flags,
   input  logic        fpu_done,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic [7:0]  rsp_flags,
   output logic        rsp_timeout
);

   typedef enum logic [1:0] {StIdle, StClr, StRun, StResp} state_e;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        prio_q;        // requester favoured when both request
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [2:0]  rm_q;
   logic        id_q;
   logic [7:0]  cnt_q;
   logic [31:0] data_q;
   logic [7:0]  flags_q;
   logic        timeout_q;

   logic        gnt_idx;
   logic        accept;
   logic [2:0]  sel_op;
   logic        timeout_hit;
   logic        busy;

   always_comb begin
      gnt_idx = (&req_valid) ? prio_q : req_valid[1];
      // rst gating keeps req_ready low while reset is held
      accept  = (state_q == StIdle) && !rst && (|req_valid);
      sel_op  = gnt_idx ? req_op[5:3] : req_op[2:0];
      req_ready = 2'b00;
      if (accept) req_ready = gnt_idx ? 2'b10 : 2'b01;
   end

   assign timeout_hit = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = (sel_op <= 3'd4) ? StClr : StResp;
         StClr:   state_d = StRun;
         StRun:   if (fpu_done || timeout_hit) state_d = StResp;
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q    <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rm_q      <= '0;
         id_q      <= 1'b0;
         cnt_q     <= '0;
         data_q    <= '0;
         flags_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (accept) begin
            op_q   <= sel_op;
            a_q    <= gnt_idx ? req_a[63:32] : req_a[31:0];
            b_q    <= gnt_idx ? req_b[63:32] : req_b[31:0];
            rm_q   <= gnt_idx ? req_rm[5:3] : req_rm[2:0];
            id_q   <= gnt_idx;
            prio_q <= ~gnt_idx;
            if (sel_op > 3'd4) begin
               // unsupported opcode: answer immediately as invalid
               data_q    <= '0;
               flags_q   <= 8'h04;
               timeout_q <= 1'b0;
            end
         end
         if (state_q == StClr) cnt_q <= '0;
         if (state_q == StRun) begin
            if (fpu_done) begin
               data_q    <= fpu_out;
               flags_q   <= fpu_flags;
               timeout_q <= 1'b0;
            end else if (timeout_hit) begin
               data_q    <= 32'h7FC0_0000;
               flags_q   <= 8'h04;
               timeout_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end
   end

   assign busy = (state_q == StClr) || (state_q == StRun);

   always_comb begin
      fpu_opcode  = busy ? op_q : 3'd0;
      fpu_in1     = busy ? a_q : 32'd0;
      fpu_in2     = busy ? b_q : 32'd0;
      fpu_round   = busy ? rm_q : 3'd0;
      fpu_act     = (state_q == StRun);
      fpu_rst     = rst || (state_q == StClr);
      rsp_valid   = (state_q == StResp);
      rsp_id      = id_q;
      rsp_data    = data_q;
      rsp_flags   = flags_q;
      rsp_timeout = timeout_q;
   end

endmodule

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max RUN cycles to wait for fpu_done, range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 2: bit i = requester i has an op pending.
REQ-005 SHALL have port req_ready, output, 2: bit i = op of requester i accepted this cycle.
REQ-006 SHALL have port req_op, input, 6: {op1,op0}, 3 bits each; 0 add, 1 mul, 2 div, 3 sqrt, 4 compare.
REQ-007 SHALL have port req_a, input, 64: {a1,a0}, 32-bit single-precision operand 1 per requester.
REQ-008 SHALL have port req_b, input, 64: {b1,b0}, 32-bit operand 2 per requester.
REQ-009 SHALL have port req_rm, input, 6: {rm1,rm0}, 3-bit rounding mode per requester.
REQ-010 SHALL have port fpu_opcode, output, 3: opcode to FPU.
REQ-011 SHALL have port fpu_in1 and fpu_in2, output, 32 each: operands to FPU.
REQ-012 SHALL have port fpu_round, output, 3: rounding mode to FPU.
REQ-013 SHALL have port fpu_rst, output, 1: FPU reset.
REQ-014 SHALL have port fpu_act, output, 1: FPU activate.
REQ-015 SHALL have port fpu_out, input, 32: FPU result.
REQ-016 SHALL have port fpu_flags, input, 8: {ov,un,less,eq,great,inv,inexact,div_zero}.
REQ-017 SHALL have port fpu_done, input, 1: FPU completion.
REQ-018 SHALL have port rsp_valid, output, 1, and rsp_ready, input, 1: response handshake.
REQ-019 SHALL have port rsp_id, output, 1: requester index of the response.
REQ-020 SHALL have ports rsp_data, output, 32; rsp_flags, output, 8, same order as fpu_flags; and rsp_timeout, output, 1.

Function
REQ-021 SHALL use FSM states IDLE, CLR, RUN, RESP.
REQ-022 SHALL assert req_ready only in IDLE, one-hot, to the granted requester, combinationally from req_valid.
REQ-023 SHALL grant by round-robin: with both requesting, grant the requester not granted last; pointer favours 0 after reset.
REQ-024 SHALL capture op, a, b, rm and grantee index into registers when req_valid[i]&req_ready[i]; accept at most one op per cycle.
REQ-025 SHALL, for an accepted op 0..4, go IDLE->CLR; CLR lasts exactly 1 cycle with fpu_rst=1 and fpu_act=0, then goes to RUN.
REQ-026 SHALL, for an accepted op 5..7, go IDLE->RESP directly: rsp_data=0, rsp_flags=8'h04 (inv only), rsp_timeout=0, no FPU activity.
REQ-027 SHALL drive fpu_act=1 and fpu_rst=0 in RUN; fpu_opcode, fpu_in1, fpu_in2 and fpu_round SHALL come from the capture registers and stay stable from CLR until leaving RUN.
REQ-028 SHALL sample fpu_done in every RUN cycle; when it is high, register fpu_out and fpu_flags into rsp_data and rsp_flags and go to RESP with rsp_timeout=0.
REQ-029 SHALL count RUN cycles from 0 with an 8-bit counter; if fpu_done is low in RUN cycle TIMEOUT-1, go to RESP with rsp_data=32'h7FC00000, rsp_flags=8'h04, rsp_timeout=1.
REQ-030 SHALL give fpu_done priority over timeout when both occur in the same cycle.
REQ-031 SHALL hold rsp_valid=1 and all rsp_* outputs stable in RESP until rsp_ready=1, then return to IDLE on the next edge.
REQ-032 SHALL make latency: accept at edge t, CLR in cycle t+1, first RUN cycle t+2, done seen in cycle d gives rsp_valid in cycle d+1 (minimum t+3).
REQ-033 SHALL give no back-to-back accept: the next accept happens no earlier than the IDLE cycle after the rsp handshake.
REQ-034 SHALL make rsp_id equal the captured grantee index.
REQ-035 SHALL drive fpu_opcode, fpu_in1, fpu_in2 and fpu_round to 0 in IDLE; fpu_act=0 outside RUN.

Reset
REQ-036 SHALL, while rst is high, force state IDLE, all registers 0, RR pointer to favour 0, rsp_valid=0, req_ready=0, fpu_act=0 and fpu_rst=1 (combinational from rst).
REQ-037 SHALL, on rst mid-operation in any state, abort the op and produce no response; first accept after rst deasserts no earlier than the next edge.

Verification
REQ-038 SHALL check: req0 add a=3F800000 b=40000000, FPU done 2 RUN cycles later with 40400000 -> rsp_valid 4 cycles after accept, rsp_data=40400000, rsp_id=0.
REQ-039 SHALL check: both requesters valid continuously, 4 ops -> grants 0,1,0,1; rsp_id sequence matches.
REQ-040 SHALL check: TIMEOUT=4, fpu_done held low -> rsp_valid after 4 RUN cycles, rsp_data=7FC00000, rsp_flags=04, rsp_timeout=1.
REQ-041 SHALL check: op=6 -> no CLR/RUN (fpu_act and fpu_rst stay 0), rsp_valid next cycle, rsp_flags=04.
REQ-042 SHALL check: rsp_ready low 5 cycles in RESP -> outputs stable and req_ready=00; rst pulse during RUN -> fpu_act=0 immediately, no response.
